load_store_unit: RTL

//   Memory-stage load/store unit. Consumes the EX/MEM register outputs (load/store flags, funct3 type,

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: aligns store lanes, runs one req/ack RAM transaction, extends loads.
// Optional REQ watchdog abort is built when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        pipe_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        fault,
    output logic [1:0]  fault_cause
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      r_state;
    logic [1:0]  r_off;
    logic [2:0]  r_type;
    logic        r_is_load;

    logic        w_op;
    logic        w_legal;
    logic        w_misal;
    logic        w_start;
    logic [2:0]  w_type;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_lane;
    logic [31:0] w_ext;
    logic        w_timeout;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_tmo_cnt;
    assign w_timeout = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog REQ waits forever; the parameter has no effect.
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        w_op    = is_load | is_store;
        w_type  = is_load ? load_type : store_type;
        w_legal = 1'b0;
        if (is_load && is_store)
            w_legal = 1'b0;
        else if (is_load)
            w_legal = load_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store)
            w_legal = store_type inside {3'b000, 3'b001, 3'b010};
        // Size lives in funct3[1:0] for every legal load and store type.
        w_misal = ((w_type[1:0] == 2'b01) && addr[0]) ||
                  ((w_type[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_start = (r_state == S_IDLE) && w_op && w_legal && !w_misal;

        case (store_type[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = store_data;
                w_wstrb = 4'b1111;
            end
        endcase

        w_lane = mem_rdata >> {r_off, 3'b000};
        case (r_type)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {24'd0, w_lane[7:0]};
            3'b101:  w_ext = {16'd0, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    assign lsu_busy = (r_state == S_REQ) || w_start;
    assign lsu_done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'd0;
            load_data   <= 32'd0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            r_is_load   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_op && !w_legal) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b10;
                    end else if (w_op && w_misal) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b01;
                    end else if (w_start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= is_store ? w_wdata : 32'd0;
                        mem_wstrb <= is_store ? w_wstrb : 4'd0;
                        r_off     <= addr[1:0];
                        r_type    <= load_type;
                        r_is_load <= is_load;
`ifdef LSU_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (r_is_load)
                            load_data <= w_ext;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        mem_req     <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                        r_state     <= S_DONE;
                    end else begin
`ifdef LSU_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    if (!pipe_stall)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
